icache_sram_arbiter: RTL and testbench
======================================

Name: icache_sram_arbiter

Overview:
- Shares the single-port instruction-cache SRAM between two requesters: the core fetch unit (read-only, back-pressurable) and the program loader/debug port (read/write).
- Arbitrates round-robin and drives the SRAM control pins directly.
- Absorbs the SRAM's fixed 1-cycle read latency with a 2-entry fetch response FIFO.
- Supports a fetch flush (branch/redirect) that discards stale fetch data.

Parameters:
ADDR_WIDTH, 13, SRAM word-address width
DATA_WIDTH, 32, data word width
NUM_WMASKS, 4, byte write-mask width (DATA_WIDTH/8)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous reset, active-low
f_req_valid_i  in  1  fetch request valid
f_req_ready_o  out  1  fetch request accepted when valid&ready
f_addr_i  in  ADDR_WIDTH  fetch word address
f_flush_i  in  1  discard all buffered and in-flight fetch responses
f_rsp_valid_o  out  1  fetch response valid
f_rsp_ready_i  in  1  fetch response consumed when valid&ready
f_rdata_o  out  DATA_WIDTH  fetch response data
l_req_valid_i  in  1  loader request valid
l_req_ready_o  out  1  loader request accepted
l_we_i  in  1  1=write, 0=read
l_addr_i  in  ADDR_WIDTH  loader address
l_wdata_i  in  DATA_WIDTH  loader write data
l_wmask_i  in  NUM_WMASKS  loader byte mask
l_rsp_valid_o  out  1  loader read data valid (1-cycle pulse, no back-pressure)
l_rdata_o  out  DATA_WIDTH  loader read data
sram_csb_o  out  1  SRAM chip select, active-low
sram_web_o  out  1  SRAM write enable, active-low (0=write)
sram_addr_o  out  ADDR_WIDTH  SRAM address
sram_wdata_o  out  DATA_WIDTH  SRAM write data
sram_wmask_o  out  NUM_WMASKS  SRAM byte mask
sram_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after a read issue

Behaviour:
- Reset: f_req_ready_o=0 while rst_ni low. Outputs f_rsp_valid_o=0, l_rsp_valid_o=0, sram_csb_o=1, sram_web_o=1, sram addr/wdata/wmask=0. FIFO empty, credit count=0, discard count=0, last_grant=LOADER so fetch wins the first tie.
- Fetch eligibility: fetch_ok = !f_flush_i && (credits<2 || (f_rsp_valid_o && f_rsp_ready_i)). credits = FIFO entries + in-flight fetch reads (0..2).
- Grant is combinational, same cycle:
  - Only one eligible requester: it wins.
  - Both eligible: the one not granted last wins.
  - last_grant updates only on an actual grant.
- f_req_ready_o = grant_fetch; l_req_ready_o = grant_loader.
- SRAM drive: combinational from the granted request. Fetch grant: csb=0, web=1, mask=0. Loader grant: csb=0, web=!l_we_i, its addr/wdata/wmask. No grant: idle values as at reset.
- Read latency: issue in cycle N; sram_rdata_i is sampled at end of N+1.
  - Fetch: data is pushed into the FIFO; f_rsp_valid_o is high from N+2 (latency 2).
  - Loader read: l_rsp_valid_o=1 and l_rdata_o=sram_rdata_i combinationally in cycle N+1 only.
  - Loader write: no response.
- Throughput: one SRAM access per cycle. Sustained 1 fetch/cycle when f_rsp_ready_i is held high.
- FIFO: depth 2, in-order, with simultaneous push and pop allowed. Overflow is impossible by the credit rule; an overflow push is an assertion failure.
- Flush (f_flush_i=1 in cycle N):
  - FIFO cleared at end of N; f_rsp_valid_o=0 from N+1.
  - A fetch read issued in N-1, whose data arrives in N, is not pushed.
  - No fetch grant occurs in N.
  - Loader traffic is unaffected.
- Ordering: SRAM accesses execute in grant order. A fetch granted after a loader write to the same address returns the new data.
- Async reset mid-operation: in-flight reads, FIFO contents and pending responses are dropped with no response pulse; outputs go to reset values immediately.

Test Plan:
1. Loader writes 0xDEADBEEF mask 0xF to addr 0x010, then fetch reads 0x010 with f_rsp_ready_i=1 -> write cycle sram_csb_o=0, sram_web_o=0; f_rsp_valid_o=1 with f_rdata_o=0xDEADBEEF exactly 2 cycles after the fetch grant.
2. Loader partial write 0x000000AA mask 0x1 over 0x11223344 at 0x020, then loader read -> l_rsp_valid_o pulses 1 cycle after grant with l_rdata_o=0x112233AA.
3. Fetch streams 0x000..0x007 with f_rsp_ready_i=1 -> f_req_ready_o stays high, 8 responses in order on 8 consecutive cycles.
4. f_rsp_ready_i=0, fetch keeps requesting -> exactly 2 grants, then f_req_ready_o=0. Raising f_rsp_ready_i drains both entries in order and fetch grants resume the same cycle as the first pop.
5. Both requesters valid for 6 cycles from reset -> grants alternate F,L,F,L,F,L.
6. Fetch issues 0x100 and 0x101, f_flush_i=1 in the cycle 0x101 data returns -> neither response ever appears. Next fetch 0x200 returns correct data 2 cycles after its grant. Repeat with rst_ni pulled low mid-stream -> all valids drop immediately and no stale response follows.

Source files
------------

// File: rtl/icache_sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// icache_sram_arbiter_if
// Requester-side bundle for the instruction-cache SRAM arbiter.
//   fetch : f_req_valid_i/f_req_ready_o/f_addr_i request channel,
//           f_flush_i discard strobe,
//           f_rsp_valid_o/f_rsp_ready_i/f_rdata_o response channel.
//   loader: l_req_valid_i/l_req_ready_o/l_we_i/l_addr_i/l_wdata_i/l_wmask_i
//           request channel, l_rsp_valid_o/l_rdata_o read-data pulse.
// The _i/_o suffixes are from the arbiter's point of view; the arbiter
// connects through the slave modport, the requesters (or a bench) through
// the master modport.
// ---------------------------------------------------------------------------
interface icache_sram_arbiter_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  // fetch unit
  logic                  f_req_valid_i;
  logic                  f_req_ready_o;
  logic [ADDR_WIDTH-1:0] f_addr_i;
  logic                  f_flush_i;
  logic                  f_rsp_valid_o;
  logic                  f_rsp_ready_i;
  logic [DATA_WIDTH-1:0] f_rdata_o;

  // program loader / debug port
  logic                  l_req_valid_i;
  logic                  l_req_ready_o;
  logic                  l_we_i;
  logic [ADDR_WIDTH-1:0] l_addr_i;
  logic [DATA_WIDTH-1:0] l_wdata_i;
  logic [NUM_WMASKS-1:0] l_wmask_i;
  logic                  l_rsp_valid_o;
  logic [DATA_WIDTH-1:0] l_rdata_o;

  modport slave (
    input  f_req_valid_i, f_addr_i, f_flush_i, f_rsp_ready_i,
    input  l_req_valid_i, l_we_i, l_addr_i, l_wdata_i, l_wmask_i,
    output f_req_ready_o, f_rsp_valid_o, f_rdata_o,
    output l_req_ready_o, l_rsp_valid_o, l_rdata_o
  );

  modport master (
    output f_req_valid_i, f_addr_i, f_flush_i, f_rsp_ready_i,
    output l_req_valid_i, l_we_i, l_addr_i, l_wdata_i, l_wmask_i,
    input  f_req_ready_o, f_rsp_valid_o, f_rdata_o,
    input  l_req_ready_o, l_rsp_valid_o, l_rdata_o
  );
endinterface

// File: rtl/icache_sram_arbiter.sv
// ---------------------------------------------------------------------------
// icache_sram_arbiter
// Shares one single-port I-cache SRAM between the fetch unit (read-only,
// back-pressurable response) and the loader/debug port (read/write, response
// is a one-cycle pulse). Round-robin grant, combinational same-cycle SRAM
// drive, 2-entry fetch response FIFO behind the SRAM's 1-cycle read latency,
// and a fetch flush that drops buffered and in-flight fetch data.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   bus (slave modport)      fetch + loader request/response channels
//   sram_csb_o, sram_web_o   SRAM chip select / write enable (active-low)
//   sram_addr_o/wdata_o/wmask_o  SRAM address, write data, byte mask
//   sram_rdata_i             SRAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module icache_sram_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  icache_sram_arbiter_if.slave  bus,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [NUM_WMASKS-1:0] sram_wmask_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  typedef enum logic {GNT_FETCH = 1'b0, GNT_LOADER = 1'b1} gnt_e;

  // state
  gnt_e                       last_gnt_q, last_gnt_d;
  logic                       f_inflight_q, f_inflight_d; // fetch read issued last cycle
  logic                       l_inflight_q, l_inflight_d; // loader read issued last cycle
  logic [1:0][DATA_WIDTH-1:0] fifo_q, fifo_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic                       wr_ptr_q, wr_ptr_d;
  logic [1:0]                 count_q, count_d;

  // combinational
  logic [1:0] credits;
  logic       f_rsp_valid;
  logic       f_pop;
  logic       f_push;
  logic       fetch_ok;
  logic       f_elig;
  logic       l_elig;
  logic       grant_f;
  logic       grant_l;

  // -------------------------------------------------------------------------
  // Eligibility and round-robin grant
  // -------------------------------------------------------------------------
  always_comb begin
    // Response is hidden during a flush so nothing stale is handed over in
    // the flush cycle itself.
    f_rsp_valid = (count_q != 2'd0) && !bus.f_flush_i;
    f_pop       = f_rsp_valid && bus.f_rsp_ready_i;
    // Data returning in a flush cycle belongs to a pre-flush request.
    f_push      = f_inflight_q && !bus.f_flush_i;
    // Every fetch in flight owns a FIFO slot, so the FIFO can never overflow.
    credits     = count_q + {1'b0, f_inflight_q};
    // A same-cycle pop frees a slot for the new request.
    fetch_ok    = !bus.f_flush_i && ((credits < 2'd2) || f_pop);
    f_elig      = rst_ni && bus.f_req_valid_i && fetch_ok;
    l_elig      = rst_ni && bus.l_req_valid_i;
    grant_f     = f_elig && (!l_elig || (last_gnt_q == GNT_LOADER));
    grant_l     = l_elig && (!f_elig || (last_gnt_q == GNT_FETCH));
  end

  // -------------------------------------------------------------------------
  // SRAM pins follow the winner in the same cycle; idle values otherwise.
  // -------------------------------------------------------------------------
  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wmask_o = '0;
    if (grant_f) begin
      sram_csb_o  = 1'b0;
      sram_addr_o = bus.f_addr_i;
    end else if (grant_l) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = !bus.l_we_i;
      sram_addr_o  = bus.l_addr_i;
      sram_wdata_o = bus.l_wdata_i;
      sram_wmask_o = bus.l_wmask_i;
    end
  end

  // -------------------------------------------------------------------------
  // Next state
  // -------------------------------------------------------------------------
  always_comb begin
    last_gnt_d   = last_gnt_q;
    f_inflight_d = grant_f;
    l_inflight_d = grant_l && !bus.l_we_i;
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (grant_f) begin
      last_gnt_d = GNT_FETCH;
    end else if (grant_l) begin
      last_gnt_d = GNT_LOADER;
    end

    if (bus.f_flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (f_push) begin
        fifo_d[wr_ptr_q] = sram_rdata_i;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (f_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, f_push} - {1'b0, f_pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_gnt_q   <= GNT_LOADER; // fetch wins the first tie
      f_inflight_q <= 1'b0;
      l_inflight_q <= 1'b0;
      fifo_q       <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      f_inflight_q <= f_inflight_d;
      l_inflight_q <= l_inflight_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.f_req_ready_o = grant_f;
  assign bus.l_req_ready_o = grant_l;
  assign bus.f_rsp_valid_o = f_rsp_valid;
  assign bus.f_rdata_o     = fifo_q[rd_ptr_q];
  // Loader read data is forwarded straight from the SRAM, no buffering.
  assign bus.l_rsp_valid_o = l_inflight_q;
  assign bus.l_rdata_o     = sram_rdata_i;

  // -------------------------------------------------------------------------
  // Invariants
  // -------------------------------------------------------------------------
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(f_push && !f_pop && (count_q == 2'd2)));
  a_credit_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    credits <= 2'd2);
  a_one_grant : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(grant_f && grant_l));

endmodule

// File: tb/tb_icache_sram_arbiter.sv
module tb_icache_sram_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) bus ();

  logic          sram_csb, sram_web;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [MW-1:0] sram_wmask;

  icache_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .sram_csb_o(sram_csb), .sram_web_o(sram_web), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_wmask_o(sram_wmask), .sram_rdata_i(sram_rdata)
  );

  function automatic logic [DW-1:0] seed_word(input int a);
    return DW'(a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // ---------------- SRAM behavioural model (environment) ----------------
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  initial begin
    logic [DW-1:0] w;
    for (int i = 0; i < (1<<AW); i++) sram_mem[i] = seed_word(i);
    sram_rdata = '0;
    forever begin
      @(posedge clk);
      if (!sram_csb && !sram_web) begin
        w = sram_mem[sram_addr];
        for (int b = 0; b < MW; b++) if (sram_wmask[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
        sram_mem[sram_addr] = w;
      end
      // Garbage when not reading, so mistimed sampling shows up.
      if (!sram_csb && sram_web) sram_rdata <= sram_mem[sram_addr];
      else                       sram_rdata <= $urandom;
    end
  end

  // ---------------- reference model ----------------
  typedef struct { logic [DW-1:0] data; int vis; } rsp_t;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  rsp_t          rq[$];        // every accepted fetch, in order, with its first visible cycle
  bit            last_l;       // loader was the last winner
  bit            lr_pend;
  logic [DW-1:0] lr_data;
  int            cyc;
  bit            e_gf, e_gl, e_fv, e_lv;
  logic [DW-1:0] e_fd, e_ld;
  int            nvec = 0;
  int            nerr = 0;

  task automatic model_reset();
    rq.delete();
    last_l  = 1'b1;
    lr_pend = 1'b0;
  endtask

  task automatic model_eval();
    bit fok, fe, le;
    e_fv = !bus.f_flush_i && (rq.size() > 0) && (rq[0].vis <= cyc);
    e_fd = e_fv ? rq[0].data : '0;
    fok  = !bus.f_flush_i && ((rq.size() < 2) || (e_fv && bus.f_rsp_ready_i));
    fe   = rst_n && bus.f_req_valid_i && fok;
    le   = rst_n && bus.l_req_valid_i;
    e_gf = fe && (!le || last_l);
    e_gl = le && (!fe || !last_l);
    e_lv = rst_n && lr_pend;
    e_ld = lr_data;
  endtask

  task automatic model_commit();
    rsp_t r;
    logic [DW-1:0] w;
    if (!rst_n) begin model_reset(); cyc++; return; end
    if (e_fv && bus.f_rsp_ready_i) rq.delete(0);
    if (bus.f_flush_i) rq.delete();
    lr_pend = 1'b0;
    if (e_gf) begin
      r.data = ref_mem[bus.f_addr_i];
      r.vis  = cyc + 2;
      rq.push_back(r);
      last_l = 1'b0;
    end
    if (e_gl) begin
      last_l = 1'b1;
      if (bus.l_we_i) begin
        w = ref_mem[bus.l_addr_i];
        for (int b = 0; b < MW; b++) if (bus.l_wmask_i[b]) w[8*b +: 8] = bus.l_wdata_i[8*b +: 8];
        ref_mem[bus.l_addr_i] = w;
      end else begin
        lr_pend = 1'b1;
        lr_data = ref_mem[bus.l_addr_i];
      end
    end
    cyc++;
  endtask

  task automatic sample();  @(negedge clk); model_eval(); endtask
  task automatic advance(); @(posedge clk); model_commit(); #1; endtask

  task automatic idle();
    bus.f_req_valid_i = 1'b0; bus.f_addr_i = '0; bus.f_flush_i = 1'b0; bus.f_rsp_ready_i = 1'b1;
    bus.l_req_valid_i = 1'b0; bus.l_we_i = 1'b0; bus.l_addr_i = '0;
    bus.l_wdata_i = '0; bus.l_wmask_i = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    bus.f_req_valid_i = 1'b1; bus.l_req_valid_i = 1'b1; bus.l_we_i = 1'b1;
    bus.l_wdata_i = 32'hFFFF_FFFF; bus.l_wmask_i = 4'hF; bus.l_addr_i = 13'h1;
    rst_n = 1'b0;
    advance(); advance();
    nvec++; if (bus.f_req_ready_o !== 1'b0) begin nerr++; $display("FAIL rst_f_ready got %b want 0", bus.f_req_ready_o); end
    nvec++; if (sram_csb !== 1'b1) begin nerr++; $display("FAIL rst_csb got %b want 1", sram_csb); end
    nvec++; if (sram_web !== 1'b1) begin nerr++; $display("FAIL rst_web got %b want 1", sram_web); end
    nvec++; if (sram_addr !== '0 || sram_wdata !== '0 || sram_wmask !== '0) begin nerr++; $display("FAIL rst_sram_bus got %h/%h/%h want 0", sram_addr, sram_wdata, sram_wmask); end
    nvec++; if (bus.f_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL rst_f_rsp_valid got %b want 0", bus.f_rsp_valid_o); end
    nvec++; if (bus.l_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL rst_l_rsp_valid got %b want 0", bus.l_rsp_valid_o); end
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_write_then_fetch();
    idle();
    bus.l_req_valid_i = 1'b1; bus.l_we_i = 1'b1; bus.l_addr_i = 13'h010;
    bus.l_wdata_i = 32'hDEADBEEF; bus.l_wmask_i = 4'hF;
    sample();
    nvec++; if (bus.l_req_ready_o !== 1'b1) begin nerr++; $display("FAIL wr_grant got %b want 1", bus.l_req_ready_o); end
    nvec++; if (sram_csb !== 1'b0 || sram_web !== 1'b0) begin nerr++; $display("FAIL wr_pins csb/web got %b%b want 00", sram_csb, sram_web); end
    nvec++; if (sram_wdata !== 32'hDEADBEEF || sram_wmask !== 4'hF) begin nerr++; $display("FAIL wr_data got %h/%h want deadbeef/f", sram_wdata, sram_wmask); end
    advance();
    idle(); bus.f_req_valid_i = 1'b1; bus.f_addr_i = 13'h010;
    sample();
    nvec++; if (bus.f_req_ready_o !== 1'b1) begin nerr++; $display("FAIL fetch_grant got %b want 1", bus.f_req_ready_o); end
    nvec++; if (sram_csb !== 1'b0 || sram_web !== 1'b1 || sram_addr !== 13'h010 || sram_wmask !== '0) begin nerr++; $display("FAIL fetch_pins got %b%b %h %h want 01 0010 0", sram_csb, sram_web, sram_addr, sram_wmask); end
    advance(); idle();
    sample();
    nvec++; if (bus.f_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL fetch_lat1 got %b want 0", bus.f_rsp_valid_o); end
    advance();
    sample();
    nvec++; if (bus.f_rsp_valid_o !== 1'b1 || bus.f_rdata_o !== 32'hDEADBEEF) begin nerr++; $display("FAIL fetch_lat2 got %b/%h want 1/deadbeef", bus.f_rsp_valid_o, bus.f_rdata_o); end
    advance();
    sample();
    nvec++; if (bus.f_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL fetch_drained got %b want 0", bus.f_rsp_valid_o); end
    advance();
  endtask

  task automatic test_partial_write();
    idle();
    bus.l_req_valid_i = 1'b1; bus.l_we_i = 1'b1; bus.l_addr_i = 13'h020;
    bus.l_wdata_i = 32'h11223344; bus.l_wmask_i = 4'hF;
    sample(); advance();
    bus.l_wdata_i = 32'h000000AA; bus.l_wmask_i = 4'h1;
    sample();
    nvec++; if (sram_wmask !== 4'h1 || sram_web !== 1'b0) begin nerr++; $display("FAIL pw_mask got %h/%b want 1/0", sram_wmask, sram_web); end
    advance();
    bus.l_we_i = 1'b0;
    sample();
    nvec++; if (bus.l_req_ready_o !== 1'b1 || sram_web !== 1'b1) begin nerr++; $display("FAIL pw_read_grant got %b/%b want 1/1", bus.l_req_ready_o, sram_web); end
    nvec++; if (bus.l_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL pw_no_wr_rsp got %b want 0", bus.l_rsp_valid_o); end
    advance(); idle();
    sample();
    nvec++; if (bus.l_rsp_valid_o !== 1'b1 || bus.l_rdata_o !== 32'h112233AA) begin nerr++; $display("FAIL pw_read_data got %b/%h want 1/112233aa", bus.l_rsp_valid_o, bus.l_rdata_o); end
    advance();
    sample();
    nvec++; if (bus.l_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL pw_pulse got %b want 0", bus.l_rsp_valid_o); end
    advance();
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_d [8];
    for (int k = 0; k < 8; k++) exp_d[k] = ref_mem[k];
    idle();
    for (int c = 0; c < 10; c++) begin
      bus.f_req_valid_i = (c < 8);
      bus.f_addr_i = AW'(c);
      sample();
      if (c < 8) begin
        nvec++; if (bus.f_req_ready_o !== 1'b1) begin nerr++; $display("FAIL stream_ready c=%0d got %b want 1", c, bus.f_req_ready_o); end
      end
      if (c >= 2) begin
        nvec++; if (bus.f_rsp_valid_o !== 1'b1 || bus.f_rdata_o !== exp_d[c-2]) begin nerr++; $display("FAIL stream_rsp c=%0d got %b/%h want 1/%h", c, bus.f_rsp_valid_o, bus.f_rdata_o, exp_d[c-2]); end
      end
      advance();
    end
    idle();
  endtask

  task automatic test_backpressure();
    int ng = 0;
    idle();
    bus.f_rsp_ready_i = 1'b0; bus.f_req_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.f_addr_i = AW'(32'h30 + ng);
      sample();
      nvec++; if (bus.f_req_ready_o !== (c < 2)) begin nerr++; $display("FAIL bp_ready c=%0d got %b want %b", c, bus.f_req_ready_o, (c < 2)); end
      if (bus.f_req_ready_o === 1'b1) ng++;
      advance();
    end
    nvec++; if (ng != 2) begin nerr++; $display("FAIL bp_grants got %0d want 2", ng); end
    bus.f_rsp_ready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.f_addr_i = AW'(32'h32 + c);
      sample();
      nvec++; if (bus.f_rsp_valid_o !== 1'b1 || bus.f_rdata_o !== ref_mem[32'h30 + c]) begin nerr++; $display("FAIL bp_drain c=%0d got %b/%h want 1/%h", c, bus.f_rsp_valid_o, bus.f_rdata_o, ref_mem[32'h30 + c]); end
      nvec++; if (bus.f_req_ready_o !== 1'b1) begin nerr++; $display("FAIL bp_resume c=%0d got %b want 1", c, bus.f_req_ready_o); end
      advance();
    end
    idle();
    for (int c = 0; c < 2; c++) begin
      sample();
      nvec++; if (bus.f_rsp_valid_o !== 1'b1 || bus.f_rdata_o !== ref_mem[32'h32 + c]) begin nerr++; $display("FAIL bp_tail c=%0d got %b/%h want 1/%h", c, bus.f_rsp_valid_o, bus.f_rdata_o, ref_mem[32'h32 + c]); end
      advance();
    end
    sample();
    nvec++; if (bus.f_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL bp_empty got %b want 0", bus.f_rsp_valid_o); end
    advance();
  endtask

  task automatic test_alternate();
    idle();
    rst_n = 1'b0; advance(); rst_n = 1'b1;
    bus.f_req_valid_i = 1'b1; bus.l_req_valid_i = 1'b1; bus.l_we_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.f_addr_i = AW'($urandom); bus.l_addr_i = AW'($urandom);
      sample();
      nvec++; if (bus.f_req_ready_o !== (c % 2 == 0) || bus.l_req_ready_o !== (c % 2 == 1)) begin nerr++; $display("FAIL rr c=%0d got F%b L%b want F%b L%b", c, bus.f_req_ready_o, bus.l_req_ready_o, (c % 2 == 0), (c % 2 == 1)); end
      advance();
    end
    idle();
    repeat (4) begin sample(); advance(); end
  endtask

  task automatic test_flush();
    idle();
    bus.f_req_valid_i = 1'b1; bus.f_addr_i = 13'h100;
    sample();
    nvec++; if (bus.f_req_ready_o !== 1'b1) begin nerr++; $display("FAIL fl_g100 got %b want 1", bus.f_req_ready_o); end
    advance();
    bus.f_addr_i = 13'h101;
    sample();
    nvec++; if (bus.f_req_ready_o !== 1'b1) begin nerr++; $display("FAIL fl_g101 got %b want 1", bus.f_req_ready_o); end
    advance();
    bus.f_flush_i = 1'b1; bus.f_addr_i = 13'h200;
    sample();
    nvec++; if (bus.f_req_ready_o !== 1'b0 || bus.f_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL fl_cycle got ready %b valid %b want 0 0", bus.f_req_ready_o, bus.f_rsp_valid_o); end
    advance();
    bus.f_flush_i = 1'b0;
    sample();
    nvec++; if (bus.f_req_ready_o !== 1'b1 || bus.f_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL fl_after got ready %b valid %b want 1 0", bus.f_req_ready_o, bus.f_rsp_valid_o); end
    advance(); idle();
    sample();
    nvec++; if (bus.f_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL fl_stale got %b want 0", bus.f_rsp_valid_o); end
    advance();
    sample();
    nvec++; if (bus.f_rsp_valid_o !== 1'b1 || bus.f_rdata_o !== ref_mem[13'h200]) begin nerr++; $display("FAIL fl_new got %b/%h want 1/%h", bus.f_rsp_valid_o, bus.f_rdata_o, ref_mem[13'h200]); end
    advance();
    sample();
    nvec++; if (bus.f_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL fl_done got %b want 0", bus.f_rsp_valid_o); end
    advance();
  endtask

  task automatic test_reset_midstream();
    idle();
    bus.f_req_valid_i = 1'b1; bus.f_addr_i = 13'h100;
    sample(); advance();
    idle(); bus.l_req_valid_i = 1'b1; bus.l_addr_i = 13'h020;
    sample(); advance();
    nvec++; if (bus.f_rsp_valid_o !== 1'b1 || bus.l_rsp_valid_o !== 1'b1) begin nerr++; $display("FAIL rm_pre got f%b l%b want 1 1", bus.f_rsp_valid_o, bus.l_rsp_valid_o); end
    bus.l_req_valid_i = 1'b0; bus.f_req_valid_i = 1'b1; bus.f_addr_i = 13'h101;
    rst_n = 1'b0;
    #1;
    nvec++; if (bus.f_rsp_valid_o !== 1'b0 || bus.l_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL rm_drop got f%b l%b want 0 0", bus.f_rsp_valid_o, bus.l_rsp_valid_o); end
    nvec++; if (bus.f_req_ready_o !== 1'b0 || sram_csb !== 1'b1) begin nerr++; $display("FAIL rm_idle got ready %b csb %b want 0 1", bus.f_req_ready_o, sram_csb); end
    advance();
    rst_n = 1'b1; idle();
    for (int c = 0; c < 4; c++) begin
      sample();
      nvec++; if (bus.f_rsp_valid_o !== 1'b0 || bus.l_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL rm_after c=%0d got f%b l%b want 0 0", c, bus.f_rsp_valid_o, bus.l_rsp_valid_o); end
      advance();
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] ea;
    idle();
    for (int c = 0; c < 1500; c++) begin
      bus.f_req_valid_i = ($urandom_range(0, 9) < 7);
      bus.f_addr_i      = AW'($urandom_range(0, 15));
      bus.f_flush_i     = ($urandom_range(0, 19) == 0);
      bus.f_rsp_ready_i = ($urandom_range(0, 9) < 6);
      bus.l_req_valid_i = ($urandom_range(0, 9) < 4);
      bus.l_we_i        = $urandom_range(0, 1);
      bus.l_addr_i      = AW'($urandom_range(0, 15));
      bus.l_wdata_i     = $urandom;
      bus.l_wmask_i     = MW'($urandom_range(0, 15));
      sample();
      nvec++; if (bus.f_req_ready_o !== e_gf || bus.l_req_ready_o !== e_gl) begin nerr++; $display("FAIL rnd_grant c=%0d got F%b L%b want F%b L%b", c, bus.f_req_ready_o, bus.l_req_ready_o, e_gf, e_gl); end
      nvec++; if (bus.f_rsp_valid_o !== e_fv) begin nerr++; $display("FAIL rnd_fvalid c=%0d got %b want %b", c, bus.f_rsp_valid_o, e_fv); end
      if (e_fv) begin
        nvec++; if (bus.f_rdata_o !== e_fd) begin nerr++; $display("FAIL rnd_fdata c=%0d got %h want %h", c, bus.f_rdata_o, e_fd); end
      end
      nvec++; if (bus.l_rsp_valid_o !== e_lv) begin nerr++; $display("FAIL rnd_lvalid c=%0d got %b want %b", c, bus.l_rsp_valid_o, e_lv); end
      if (e_lv) begin
        nvec++; if (bus.l_rdata_o !== e_ld) begin nerr++; $display("FAIL rnd_ldata c=%0d got %h want %h", c, bus.l_rdata_o, e_ld); end
      end
      nvec++; if (sram_csb !== !(e_gf || e_gl)) begin nerr++; $display("FAIL rnd_csb c=%0d got %b want %b", c, sram_csb, !(e_gf || e_gl)); end
      if (e_gf || e_gl) begin
        ea = e_gf ? bus.f_addr_i : bus.l_addr_i;
        nvec++; if (sram_addr !== ea || sram_web !== (e_gf ? 1'b1 : !bus.l_we_i)) begin nerr++; $display("FAIL rnd_pins c=%0d got %h/%b want %h/%b", c, sram_addr, sram_web, ea, (e_gf ? 1'b1 : !bus.l_we_i)); end
      end
      if (e_gl && bus.l_we_i) begin
        nvec++; if (sram_wdata !== bus.l_wdata_i || sram_wmask !== bus.l_wmask_i) begin nerr++; $display("FAIL rnd_wr c=%0d got %h/%h want %h/%h", c, sram_wdata, sram_wmask, bus.l_wdata_i, bus.l_wmask_i); end
      end
      advance();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = seed_word(i);
    cyc = 0;
    model_reset();
    idle();
    test_reset();
    test_write_then_fetch();
    test_partial_write();
    test_stream();
    test_backpressure();
    test_alternate();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
